// File: rtl/font_rom_arbiter_if.sv
// font_rom_arbiter_if: requester-side request/response bundle of the font ROM arbiter
interface font_rom_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 16
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_lock;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_data;
    modport master (output req_valid, req_lock, req_addr, input req_ready, rsp_valid, rsp_data);
    modport slave  (input req_valid, req_lock, req_addr, output req_ready, rsp_valid, rsp_data);
endinterface

// File: rtl/font_rom_arbiter.sv
// font_rom_arbiter: round-robin, burst-lockable sharing of one font_rom read port among NUM_REQ requesters
module font_rom_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int ADDR_W    = 9,
    parameter int DATA_W    = 16,
    parameter int ROM_LAT   = 1,
    parameter int MAX_BURST = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    font_rom_arbiter_if.slave bus,
    output logic [ADDR_W-1:0] o_rom_addr,
    input  logic [DATA_W-1:0] i_rom_data,
    output logic              o_busy
);
    localparam int PW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MAX_BURST + 1);
    typedef enum logic {ARB, LOCKED} state_t;
    state_t           r_state, w_state;
    logic [PW-1:0]    r_ptr, w_ptr, r_owner, w_owner, w_win, w_idx;
    logic [CW-1:0]    r_cnt, w_cnt, w_beat;
    logic             w_found, w_cont;
    logic [ROM_LAT:0] r_tv;
    logic [PW-1:0]    r_tid [0:ROM_LAT];
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        w_cont  = r_state == LOCKED && bus.req_valid[r_owner];
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = PW'((int'(r_ptr) + k) % NUM_REQ);
            if (!w_found && bus.req_valid[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
        // a still-valid burst owner overrides the round-robin choice
        if (w_cont) w_win = r_owner;
        w_beat  = w_cont ? r_cnt + 1'b1 : CW'(1);
        w_ptr   = w_found ? (w_win == PW'(NUM_REQ - 1) ? '0 : w_win + 1'b1) : r_ptr;
        w_owner = w_found ? w_win : r_owner;
        w_state = w_found && bus.req_lock[w_win] && w_beat != CW'(MAX_BURST) ? LOCKED : ARB;
        w_cnt   = w_state == LOCKED ? w_beat : '0;
    end
    assign bus.req_ready = w_found ? NUM_REQ'(1) << w_win : '0;
    assign bus.rsp_valid = r_tv[ROM_LAT] ? NUM_REQ'(1) << r_tid[ROM_LAT] : '0;
    assign bus.rsp_data  = i_rom_data;
    assign o_busy        = |r_tv;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ARB;
            r_ptr      <= '0;
            r_owner    <= '0;
            r_cnt      <= '0;
            o_rom_addr <= '0;
            r_tv       <= '0;
            r_tid      <= '{default: '0};
        end else begin
            r_state  <= w_state;
            r_ptr    <= w_ptr;
            r_owner  <= w_owner;
            r_cnt    <= w_cnt;
            if (w_found) o_rom_addr <= bus.req_addr[w_win * ADDR_W +: ADDR_W];
            r_tv[0]  <= w_found;
            r_tid[0] <= w_win;
            for (int i = 1; i <= ROM_LAT; i++) begin
                r_tv[i]  <= r_tv[i-1];
                r_tid[i] <= r_tid[i-1];
            end
        end
    end
endmodule

// File: tb/tb_font_rom_arbiter.sv
// tb_font_rom_arbiter: randomized bench comparing the arbiter against a queue-based behavioural model
module tb_font_rom_arbiter;
    localparam int N = 4, AW = 9, DW = 16, MAXB = 16;
    logic          clk, rst_n;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data;
    logic          busy;
    logic [DW-1:0] rom [0:(1<<AW)-1];
    int            total, bad, cyc;
    typedef struct {int due; int id; logic [AW-1:0] addr;} ent_t;
    ent_t          q[$];
    int            m_ptr, m_owner, m_burst;
    logic [AW-1:0] m_addr;
    font_rom_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();
    font_rom_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(1), .MAX_BURST(MAXB)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .o_rom_addr(rom_addr), .i_rom_data(rom_data), .o_busy(busy));
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) rom_data <= rom[rom_addr];
    task automatic chk(string n, logic [31:0] a, logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", n, a, e, $time);
        end
    endtask
    // round robin from the pointer, unless a still-requesting burst owner holds the port
    function automatic int exp_grant();
        if (m_owner >= 0 && bus.req_valid[m_owner]) return m_owner;
        for (int k = 0; k < N; k++) if (bus.req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction
    always @(negedge clk) begin : model
        int g;
        cyc++;
        if (!rst_n) begin
            chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
            chk("rst_rom_addr", 32'(rom_addr), 0);
            chk("rst_busy", 32'(busy), 0);
            q.delete();
            m_ptr = 0; m_owner = -1; m_burst = 0; m_addr = '0;
        end else begin
            g = exp_grant();
            chk("ready", 32'(bus.req_ready), g < 0 ? 32'd0 : 32'd1 << g);
            chk("rom_addr", 32'(rom_addr), 32'(m_addr));
            chk("busy", 32'(busy), 32'(q.size() != 0));
            if (q.size() != 0 && q[0].due == cyc) begin
                chk("rsp_valid", 32'(bus.rsp_valid), 32'd1 << q[0].id);
                chk("rsp_data", 32'(bus.rsp_data), 32'(rom[q[0].addr]));
                void'(q.pop_front());
            end else chk("rsp_idle", 32'(bus.rsp_valid), 0);
            if (g >= 0) begin
                m_addr = bus.req_addr[g*AW +: AW];
                q.push_back('{cyc + 2, g, m_addr});
                m_burst = (m_owner == g) ? m_burst + 1 : 1;
                if (bus.req_lock[g] && m_burst < MAXB) m_owner = g;
                else begin m_owner = -1; m_burst = 0; end
                m_ptr = (g + 1) % N;
            end else begin
                m_owner = -1; m_burst = 0;
            end
        end
    end
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic set_req(int i, bit v, bit l, int a);
        bus.req_valid[i] = v;
        bus.req_lock[i] = l;
        bus.req_addr[i*AW +: AW] = AW'(a);
    endtask
    task automatic idle();
        bus.req_valid = '0;
        bus.req_lock = '0;
        bus.req_addr = '0;
    endtask
    task automatic do_reset();
        step();
        rst_n = 1'b0;
        idle();
        step();
        rst_n = 1'b1;
    endtask
    initial begin
        int vp, lp;
        total = 0; bad = 0; cyc = 0;
        for (int a = 0; a < (1 << AW); a++) rom[a] = DW'($urandom);
        rst_n = 1'b1;
        idle();
        #2 rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        // single request from requester 0
        set_req(0, 1, 0, 'h010);
        @(negedge clk) chk("t2_ready", 32'(bus.req_ready), 1);
        step(); idle();
        @(negedge clk) chk("t2_rom_addr", 32'(rom_addr), 'h010);
        step();
        @(negedge clk) begin
            chk("t2_rsp_valid", 32'(bus.rsp_valid), 1);
            chk("t2_rsp_data", 32'(bus.rsp_data), 32'(rom['h010]));
        end
        // all four requesting, no lock
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 1, 0, $urandom);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk) begin
                chk("t3_grant", 32'(bus.req_ready), 32'd1 << (i % 4));
                if (i >= 2) chk("t3_rsp", 32'(bus.rsp_valid), 32'd1 << ((i - 2) % 4));
            end
            step();
        end
        // requester 1 locked burst of 16 rows while 0 and 2 compete
        do_reset();
        set_req(0, 1, 0, 'h1AB);
        step();
        set_req(1, 1, 1, 'h070);
        set_req(2, 1, 0, 'h120);
        for (int b = 0; b < 16; b++) begin
            @(negedge clk) begin
                chk("t4_burst", 32'(bus.req_ready), 2);
                if (b >= 2) chk("t4_rsp", 32'(bus.rsp_valid), 2);
            end
            step();
            set_req(1, 1, 1, 'h070 + b + 1);
        end
        set_req(1, 0, 0, 0);
        @(negedge clk) chk("t4_after", 32'(bus.req_ready), 4);
        step(); idle();
        // requester 3 tries to hold the lock for 20 beats
        do_reset();
        set_req(3, 1, 1, $urandom);
        for (int b = 0; b < 20; b++) begin
            @(negedge clk) chk("t5_grant", 32'(bus.req_ready), b == 16 ? 32'd1 : 32'd8);
            step();
            if (b == 0) set_req(0, 1, 0, $urandom);
            set_req(3, 1, 1, $urandom);
        end
        idle();
        // locked owner drops valid after 5 beats
        do_reset();
        set_req(2, 1, 1, $urandom);
        for (int b = 0; b < 5; b++) begin
            @(negedge clk) chk("t6_burst", 32'(bus.req_ready), 4);
            step();
            if (b == 0) set_req(0, 1, 0, $urandom);
            set_req(2, 1, 1, $urandom);
        end
        set_req(2, 0, 0, 0);
        @(negedge clk) chk("t6_handover", 32'(bus.req_ready), 1);
        step(); idle();
        repeat (4) step();
        // randomized traffic with occasional mid-stream resets
        vp = 12; lp = 8;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) begin
                vp = $urandom_range(4, 16);
                lp = $urandom_range(0, 16);
            end
            for (int i = 0; i < N; i++)
                set_req(i, $urandom % 16 < vp, $urandom % 16 < lp, $urandom);
            rst_n = ($urandom % 400) != 0;
            step();
        end
        rst_n = 1'b1;
        idle();
        repeat (5) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
